sr_pulse_gen: RTL and testbench
===============================

SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive stable clock cycles required to accept a new input level; legal range 1..255.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-004 The block SHALL have port btn_set  input  1  raw, asynchronous set request, e.g. a push-button.
REQ-005 The block SHALL have port btn_rst  input  1  raw, asynchronous reset request, e.g. a push-button.
REQ-006 The block SHALL have port s  output  1  one-cycle set pulse, registered, for the downstream SR flip-flop s input.
REQ-007 The block SHALL have port r  output  1  one-cycle reset pulse, registered, for the downstream SR flip-flop r input.
REQ-008 The block SHALL have port conflict  output  1  one-cycle pulse, registered, flagging a suppressed simultaneous set and reset.

Function
REQ-009 Each input SHALL pass through its own 2-flop synchronizer (sync1 then sync2) before any other logic.
REQ-010 Each channel SHALL hold a debounced level db, reset 0, and an 8-bit stability counter cnt, reset 0.
REQ-011 When sync2 equals db, cnt SHALL clear to 0 on the next edge.
REQ-012 When sync2 differs from db and cnt < DEBOUNCE-1, cnt SHALL increment.
REQ-013 When sync2 differs from db and cnt = DEBOUNCE-1, db SHALL take the sync2 value and cnt SHALL clear to 0.
REQ-014 Any single-cycle return of sync2 to db SHALL restart the count from 0; glitches shorter than DEBOUNCE cycles SHALL never change db.
REQ-015 A channel SHALL report a "rise" on the edge where its db goes 0->1; a db 1->0 transition (release) SHALL generate no output.
REQ-016 If only the set channel rises, s SHALL be 1 for exactly one cycle, starting at the edge after the rise; r and conflict SHALL stay 0.
REQ-017 If only the reset channel rises, r SHALL be 1 for exactly one cycle, starting at the edge after the rise; s and conflict SHALL stay 0.
REQ-018 If both channels rise on the same edge, s and r SHALL both stay 0 and conflict SHALL be 1 for one cycle.
REQ-019 s and r SHALL never be 1 in the same cycle.
REQ-020 Latency SHALL be as follows: edge 0 is the first edge at which btn_x is sampled at its new level into sync1; if the level holds, the output pulse SHALL be high during the cycle following edge DEBOUNCE+2 (edge 6 for DEBOUNCE=4).
REQ-021 A button held high SHALL produce exactly one pulse per press; a new pulse SHALL require a debounced release followed by a debounced press.
REQ-022 Rises on different edges SHALL produce separate pulses, even one cycle apart.
REQ-023 The two channels SHALL be fully independent except for the REQ-018 coincidence check.

Reset
REQ-024 While rst=0, all synchronizer flops, db, cnt, s, r and conflict SHALL be 0 immediately, independent of clk.
REQ-025 Reset asserted mid-count SHALL discard partial counts; no pulse SHALL follow for the interrupted transition.
REQ-026 After rst rises with a button already held high, that button SHALL be treated as a new press: one pulse at the REQ-020 latency, counted from the first edge after release.

Verification
REQ-027 Scenario single press: DEBOUNCE=4, rst=1, btn_set 0->1 held 20 cycles -> s=1 only in the cycle after edge 6; r=0 and conflict=0 throughout.
REQ-028 Scenario glitch: btn_rst high for 3 cycles then low, DEBOUNCE=4 -> r stays 0; reset-channel db stays 0.
REQ-029 Scenario coincidence: btn_set and btn_rst rise on the same edge, both held -> s=0 and r=0; conflict=1 for one cycle after edge 6.
REQ-030 Scenario staggered: btn_set rises at edge 0, btn_rst rises at edge 1 -> s pulse after edge 6, r pulse after edge 7, conflict=0.
REQ-031 Scenario reset mid-operation: btn_set rises, rst=0 at edge 3 for 2 cycles, btn_set held throughout -> no pulse before reset release; then exactly one s pulse DEBOUNCE+2 edges after the first post-reset edge.
REQ-032 Scenario chaining: connect s and r to an SR flip-flop; apply set press, then reset press, then simultaneous press -> q goes 1, then 0, then remains 0 with conflict pulsed.

Source files
------------

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: synchronizes and debounces two push-buttons into one-cycle
// set/reset pulses for an SR flip-flop, suppressing coincident presses.
module sr_pulse_gen #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s,
  output logic r,
  output logic conflict
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);
  logic [1:0]      sync1_q, sync2_q, db_q, db_d, db_prev_q, rise;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic            s_q, r_q, conflict_q, s_d, r_d, conflict_d;
  // channel 0 is set, channel 1 is reset
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = (sync2_q[i] != db_q[i] && cnt_q[i] == LAST) ? sync2_q[i] : db_q[i];
      cnt_d[i] = (sync2_q[i] == db_q[i] || cnt_q[i] == LAST) ? 8'd0 : cnt_q[i] + 8'd1;
    end
    rise       = db_q & ~db_prev_q;
    s_d        = rise[0] & ~rise[1];
    r_d        = rise[1] & ~rise[0];
    conflict_d = rise[0] & rise[1];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      cnt_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sync1_q    <= {btn_rst, btn_set};
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end
  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb_sr_pulse_gen: directed scenarios plus randomized button activity checked
// against a run-length debounce model.
module tb_sr_pulse_gen;
  localparam int DEBOUNCE = 4;
  logic clk = 1'b0, rst = 1'b0, btn_set = 1'b0, btn_rst = 1'b0;
  logic s, r, conflict;
  logic q = 1'b0;
  int vectors = 0, miscompares = 0;
  // model: raw samples delayed two edges, per-channel run length of disagreement
  logic [1:0] h1, h2, mdb, prise;
  int run [2];
  logic exp_s, exp_r, exp_c;

  sr_pulse_gen #(.DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_rst(btn_rst),
    .s(s), .r(r), .conflict(conflict)
  );

  always #5 clk = ~clk;
  always @(posedge clk) q <= s ? 1'b1 : r ? 1'b0 : q;

  task automatic tick();
    logic [1:0] rn;
    @(posedge clk);
    if (!rst) begin
      h1 = '0; h2 = '0; mdb = '0; prise = '0; run[0] = 0; run[1] = 0;
      exp_s = 0; exp_r = 0; exp_c = 0;
    end else begin
      rn = '0;
      for (int c = 0; c < 2; c++) begin
        run[c] = (h2[c] != mdb[c]) ? run[c] + 1 : 0;
        if (run[c] == DEBOUNCE) begin
          rn[c] = h2[c];
          mdb[c] = h2[c];
          run[c] = 0;
        end
      end
      exp_s = prise[0] & ~prise[1];
      exp_r = prise[1] & ~prise[0];
      exp_c = prise[0] & prise[1];
      prise = rn;
      h2 = h1;
      h1 = {btn_rst, btn_set};
    end
    #1;
  endtask

  task automatic idle(input int n);
    btn_set = 0; btn_rst = 0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({s, r, conflict, dut.db_q} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_hold: s/r/c/db=%b%b%b%b want 00000", s, r, conflict, dut.db_q);
    end
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({s, r, conflict} !== 3'b0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: s/r/c=%b%b%b want 000", i, s, r, conflict);
      end
    end
  endtask

  task automatic test_single_press();
    btn_set = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({s, r, conflict} !== {i == 6, 2'b00}) begin
        miscompares++;
        $display("FAIL single_press edge %0d: s/r/c=%b%b%b want %b00", i, s, r, conflict, i == 6);
      end
    end
    idle(12);
  endtask

  task automatic test_glitch();
    btn_rst = 1;
    for (int i = 0; i < 18; i++) begin
      if (i == 3) btn_rst = 0;
      tick();
      vectors++;
      if ({r, dut.db_q[1]} !== 2'b00) begin
        miscompares++;
        $display("FAIL glitch edge %0d: r/db=%b%b want 00", i, r, dut.db_q[1]);
      end
    end
  endtask

  task automatic test_coincidence();
    btn_set = 1; btn_rst = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({s, r, conflict} !== {2'b00, i == 6}) begin
        miscompares++;
        $display("FAIL coincidence edge %0d: s/r/c=%b%b%b want 00%b", i, s, r, conflict, i == 6);
      end
    end
    idle(12);
  endtask

  task automatic test_staggered();
    btn_set = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      btn_rst = 1;
      vectors++;
      if ({s, r, conflict} !== {i == 6, i == 7, 1'b0}) begin
        miscompares++;
        $display("FAIL staggered edge %0d: s/r/c=%b%b%b want %b%b0", i, s, r, conflict, i == 6, i == 7);
      end
    end
    idle(12);
  endtask

  task automatic test_reset_mid();
    btn_set = 1;
    repeat (3) tick();
    rst = 0;
    #1;
    vectors++;
    if ({s, r, conflict, dut.db_q, dut.cnt_q[0]} !== 13'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: s/r/c=%b%b%b db=%b cnt=%0d want all 0", s, r, conflict, dut.db_q, dut.cnt_q[0]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({s, r, conflict} !== 3'b0) begin
        miscompares++;
        $display("FAIL reset_mid_hold[%0d]: s/r/c=%b%b%b want 000", i, s, r, conflict);
      end
    end
    rst = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if ({s, r, conflict} !== {i == 6, 2'b00}) begin
        miscompares++;
        $display("FAIL reset_mid_after edge %0d: s/r/c=%b%b%b want %b00", i, s, r, conflict, i == 6);
      end
    end
    idle(12);
  endtask

  task automatic test_async_kill();
    btn_rst = 1;
    repeat (7) tick();
    vectors++;
    if (r !== 1'b1) begin
      miscompares++;
      $display("FAIL async_kill_pre: r=%b want 1", r);
    end
    #2 rst = 0;
    #1;
    vectors++;
    if (r !== 1'b0) begin
      miscompares++;
      $display("FAIL async_kill: r=%b want 0", r);
    end
    tick();
    rst = 1;
    idle(12);
  endtask

  task automatic test_chaining();
    int nc;
    nc = 0;
    btn_set = 1; repeat (10) tick(); idle(10);
    vectors++;
    if (q !== 1'b1) begin miscompares++; $display("FAIL chain_set: q=%b want 1", q); end
    btn_rst = 1; repeat (10) tick(); idle(10);
    vectors++;
    if (q !== 1'b0) begin miscompares++; $display("FAIL chain_reset: q=%b want 0", q); end
    btn_set = 1; btn_rst = 1;
    repeat (10) begin tick(); nc += conflict; end
    idle(10);
    vectors++;
    if (q !== 1'b0 || nc != 1) begin
      miscompares++;
      $display("FAIL chain_both: q=%b conflicts=%0d want q=0 conflicts=1", q, nc);
    end
  endtask

  task automatic test_random();
    int hold [2];
    hold[0] = 1; hold[1] = 1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          if (c == 0) btn_set = ~btn_set; else btn_rst = ~btn_rst;
          hold[c] = (($urandom & 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(3, 12));
        end
      end
      if (i == 700) rst = 0;
      if (i == 703) rst = 1;
      tick();
      vectors++;
      if ({s, r, conflict} !== {exp_s, exp_r, exp_c} || (s & r)) begin
        miscompares++;
        $display("FAIL random cyc %0d: s/r/c=%b%b%b want %b%b%b", i, s, r, conflict, exp_s, exp_r, exp_c);
      end
    end
    idle(12);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_coincidence();
    test_staggered();
    test_reset_mid();
    test_async_kill();
    test_chaining();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
